picorv32_mem_responder: RTL and testbench
=========================================

Name: picorv32_mem_responder

Overview:
- Target side of the PicoRV32 native memory bus (valid/ready, byte strobes). Answers every core request with a configurable number of wait states.
- Serves three address regions:
  - a byte-writable word RAM for instructions and data;
  - a small MMIO register bank: GPIO output, simulation-done flag, free-running cycle counter;
  - an error path for unmapped addresses.
- Sits beside the core wrapper in the SoC top level and in standalone test benches.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words (4 KiB). Power of two. RAM occupies byte addresses 0 .. 4*MEM_WORDS-1.
- WAIT_STATES, 0: extra cycles before mem_ready. Legal range 0..15.
- MMIO_BASE, 32'h1000_0000: base byte address of the MMIO bank.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned for unmapped addresses.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  request present; held by the core until mem_ready.
- mem_instr  input  1  request is an instruction fetch; used for counting only.
- mem_addr  input  32  byte address; bits [1:0] ignored.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte write enables; 0 means read.
- mem_ready  output  1  one-cycle response strobe.
- mem_rdata  output  32  read data, valid while mem_ready=1.
- gpio_out  output  32  MMIO GPIO register.
- sim_done  output  1  sticky; set by any write to the DONE register.
- bus_error  output  1  sticky; set by any access to an unmapped address.
- fetch_count  output  32  count of completed instruction fetches; wraps.

Behaviour:
- Reset: asynchronous. All outputs go to 0 immediately. State goes to IDLE; wait counter, cycle counter and fetch_count clear. RAM contents are not reset (undefined until written).
- Reset mid-transaction aborts the transaction: no write is committed and no mem_ready is issued. A mem_valid still high after reset deasserts is accepted on the first clock edge.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on an edge with mem_valid=1, capture addr, wdata, wstrb and instr. Load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: decrement the counter each edge. When it reaches 1, go to RESP on that edge.
  - RESP: mem_ready=1 for exactly this cycle. The next edge returns to IDLE.
- Latency: mem_ready rises WAIT_STATES+1 cycles after the accepting edge. It is registered, with no combinational path from mem_valid.
- Back-to-back: a new request may be accepted on the first IDLE edge after RESP. Throughput is one transaction per WAIT_STATES+2 cycles.
- Commit and data timing:
  - Writes commit on the edge entering RESP, from captured values, per enabled byte only.
  - mem_rdata is registered on that same edge and holds until the next response.
  - For writes, mem_rdata returns the pre-write word (don't-care for the core).
- mem_valid falling before mem_ready is a protocol violation. The captured transaction still completes normally.
- Address decode (word address = mem_addr[31:2]):
  - RAM region: word index = mem_addr[log2(MEM_WORDS)+1:2].
  - MMIO_BASE+0x0, GPIO_OUT: read/write, byte strobes honoured.
  - MMIO_BASE+0x4, DONE: writes with any strobe set sim_done. Reads return {31'b0, sim_done}.
  - MMIO_BASE+0x8, CYCLES: read-only. The 32-bit cycle counter increments every clock from reset and wraps 0xFFFF_FFFF to 0. A read returns the value at the commit edge; writes are ignored.
  - Any other address: reads return ERR_RDATA, writes are ignored, and bus_error is set. The access still completes with mem_ready, so the bus never hangs.
- fetch_count increments on the RESP-entry edge when the captured instr=1, for any region. It wraps.
- Unused MMIO offsets inside the bank count as unmapped.

Decomposition:
- Shared package picorv32_mem_pkg holds:
  - the FSM state enum;
  - the MMIO offset constants GPIO=0x0, DONE=0x4, CYCLES=0x8;
  - the region-decode function.
- One sub-module, mem_sp_ram_bytewe: single-port, one-cycle, 4-lane byte-write RAM with MEM_WORDS depth and no reset. It maps to an SRAM macro later.

Test Plan:
- Default WAIT_STATES=0: write 0xA5A5_1234 to 0x40 with wstrb=4'hF, then read 0x40. mem_ready comes 1 cycle after each accept, rdata=0xA5A5_1234, bus_error=0.
- Byte strobes: write 0xFFFF_FFFF to 0x80, then write 0x0000_0000 with wstrb=4'b0101, then read. rdata=0xFF00_FF00.
- WAIT_STATES=3: a held read completes with mem_ready high exactly 4 cycles after the accepting edge, for exactly 1 cycle. Back-to-back requests give one transaction per 5 cycles.
- MMIO:
  - write 0x0000_00C3 to 0x1000_0000: gpio_out=0xC3;
  - write to 0x1000_0004: sim_done=1 and stays set;
  - two CYCLES reads N cycles apart differ by N.
- Unmapped read at 0x2000_0000: rdata=0xDEAD_BEEF, mem_ready still issued, bus_error=1 and sticky. A following RAM access works normally.
- Assert reset in WAIT while writing 0x55 to 0x10 (WAIT_STATES=2): mem_ready never pulses, outputs read 0, and a RAM read of 0x10 after reset does not return 0x55 (sentinel written before the test).

Source files
------------

// File: rtl/picorv32_mem_pkg.sv
// Shared types and address decode for the PicoRV32 memory responder.
// The region decode lives here so the top and any bus monitors agree on the map.
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    RGN_RAM    = 3'd0,
    RGN_GPIO   = 3'd1,
    RGN_DONE   = 3'd2,
    RGN_CYCLES = 3'd3,
    RGN_ERR    = 3'd4
  } region_t;

  localparam logic [31:0] MMIO_OFF_GPIO   = 32'h0000_0000;
  localparam logic [31:0] MMIO_OFF_DONE   = 32'h0000_0004;
  localparam logic [31:0] MMIO_OFF_CYCLES = 32'h0000_0008;

  // RAM wins over MMIO if the two ever overlap; unused MMIO offsets fall to RGN_ERR.
  function automatic region_t decode_region(
    input logic [31:0] addr,
    input logic [31:0] mem_words,
    input logic [31:0] mmio_base
  );
    logic [31:0] w_word;
    logic [31:0] w_aligned;
    w_word    = {2'b00, addr[31:2]};
    w_aligned = {addr[31:2], 2'b00};
    if (w_word < mem_words)                           return RGN_RAM;
    else if (w_aligned == mmio_base + MMIO_OFF_GPIO)   return RGN_GPIO;
    else if (w_aligned == mmio_base + MMIO_OFF_DONE)   return RGN_DONE;
    else if (w_aligned == mmio_base + MMIO_OFF_CYCLES) return RGN_CYCLES;
    else                                               return RGN_ERR;
  endfunction

endpackage

// File: rtl/mem_sp_ram_bytewe.sv
// Single-port word RAM with four byte-write lanes and a registered read port.
// Read-before-write: o_rdata returns the word as it was before this edge's write.
module mem_sp_ram_bytewe #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/picorv32_mem_responder.sv
// Target side of the PicoRV32 native memory bus: RAM, a small MMIO bank and an
// error region, answering each request after WAIT_STATES extra cycles.
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] gpio_out,
  output logic        sim_done,
  output logic        bus_error,
  output logic [31:0] fetch_count
);

  // Handshake: a request is taken on any IDLE edge with mem_valid=1; the core
  // must hold it until mem_ready, which is a registered one-cycle strobe.

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_instr;
  logic        r_ready;
  logic [31:0] r_rdata_reg;
  logic        r_rdata_ram_sel;
  logic [31:0] r_gpio;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_fetch;
  logic [31:0] r_cycles;

  logic        w_in_idle;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_instr;
  logic        w_commit;
  logic        w_write;
  region_t     w_region;
  logic        w_ram_en;
  logic [31:0] w_ram_rdata;

  // With zero wait states the commit edge is the accepting edge, so the live
  // bus fields are used; otherwise the captured copies are.
  always_comb begin
    w_in_idle = (r_state == ST_IDLE);
    w_addr    = w_in_idle ? mem_addr  : r_addr;
    w_wdata   = w_in_idle ? mem_wdata : r_wdata;
    w_wstrb   = w_in_idle ? mem_wstrb : r_wstrb;
    w_instr   = w_in_idle ? mem_instr : r_instr;
    w_commit  = !reset && ((w_in_idle && mem_valid && (WS == 4'd0)) ||
                           ((r_state == ST_WAIT) && (r_cnt == 4'd1)));
    w_write   = |w_wstrb;
    w_region  = decode_region(w_addr, 32'(MEM_WORDS), MMIO_BASE);
    w_ram_en  = w_commit && (w_region == RGN_RAM);
  end

  mem_sp_ram_bytewe #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_wstrb),
    .i_addr  (w_addr[AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= 4'd0;
      r_addr          <= 32'd0;
      r_wdata         <= 32'd0;
      r_wstrb         <= 4'd0;
      r_instr         <= 1'b0;
      r_ready         <= 1'b0;
      r_rdata_reg     <= 32'd0;
      r_rdata_ram_sel <= 1'b0;
      r_gpio          <= 32'd0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_fetch         <= 32'd0;
      r_cycles        <= 32'd0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      r_ready  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (mem_valid) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_instr <= mem_instr;
            r_cnt   <= WS;
            r_state <= (WS == 4'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_commit) begin
        r_ready         <= 1'b1;
        r_rdata_ram_sel <= (w_region == RGN_RAM);
        if (w_instr) r_fetch <= r_fetch + 32'd1;
        case (w_region)
          RGN_GPIO: begin
            r_rdata_reg <= r_gpio;
            for (int b = 0; b < 4; b++) begin
              if (w_wstrb[b]) r_gpio[8*b +: 8] <= w_wdata[8*b +: 8];
            end
          end
          RGN_DONE: begin
            r_rdata_reg <= {31'd0, r_done};
            if (w_write) r_done <= 1'b1;
          end
          RGN_CYCLES: r_rdata_reg <= r_cycles;
          RGN_ERR: begin
            r_rdata_reg <= ERR_RDATA;
            r_err       <= 1'b1;
          end
          default: r_rdata_reg <= 32'd0;
        endcase
      end
    end
  end

  // RAM read data is already registered inside the RAM and only changes on a
  // RAM commit, so this mux still presents a stable, registered value.
  assign mem_ready   = r_ready;
  assign mem_rdata   = r_rdata_ram_sel ? w_ram_rdata : r_rdata_reg;
  assign gpio_out    = r_gpio;
  assign sim_done    = r_done;
  assign bus_error   = r_err;
  assign fetch_count = r_fetch;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench for picorv32_mem_responder: three instances with 0, 3 and 2
// wait states, each driven by its own set of bus signals.
module tb_picorv32_mem_responder;

  localparam logic [31:0] MMIO = 32'h1000_0000;

  logic        clk = 1'b0;
  int unsigned tb_cyc = 0;

  logic        rst_a    [3];
  logic        valid_a  [3];
  logic        instr_a  [3];
  logic [31:0] addr_a   [3];
  logic [31:0] wdata_a  [3];
  logic [3:0]  wstrb_a  [3];
  logic        ready_a  [3];
  logic [31:0] rdata_a  [3];
  logic [31:0] gpio_a   [3];
  logic        done_a   [3];
  logic        err_a    [3];
  logic [31:0] fc_a     [3];

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd, c1, c2, c3;
  int          lat, n;
  int unsigned t1, t2, t3;
  logic        saw_ready;

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  picorv32_mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst_a[0]), .mem_valid(valid_a[0]), .mem_instr(instr_a[0]),
    .mem_addr(addr_a[0]), .mem_wdata(wdata_a[0]), .mem_wstrb(wstrb_a[0]),
    .mem_ready(ready_a[0]), .mem_rdata(rdata_a[0]), .gpio_out(gpio_a[0]),
    .sim_done(done_a[0]), .bus_error(err_a[0]), .fetch_count(fc_a[0]));

  picorv32_mem_responder #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(rst_a[1]), .mem_valid(valid_a[1]), .mem_instr(instr_a[1]),
    .mem_addr(addr_a[1]), .mem_wdata(wdata_a[1]), .mem_wstrb(wstrb_a[1]),
    .mem_ready(ready_a[1]), .mem_rdata(rdata_a[1]), .gpio_out(gpio_a[1]),
    .sim_done(done_a[1]), .bus_error(err_a[1]), .fetch_count(fc_a[1]));

  picorv32_mem_responder #(.WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(rst_a[2]), .mem_valid(valid_a[2]), .mem_instr(instr_a[2]),
    .mem_addr(addr_a[2]), .mem_wdata(wdata_a[2]), .mem_wstrb(wstrb_a[2]),
    .mem_ready(ready_a[2]), .mem_rdata(rdata_a[2]), .gpio_out(gpio_a[2]),
    .sim_done(done_a[2]), .bus_error(err_a[2]), .fetch_count(fc_a[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on instance d; returns read data and the number of negedges
  // from the drive point until mem_ready is seen (bounded at 40).
  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] w,
                      input logic [3:0] s, input logic ins,
                      output logic [31:0] rdo, output int lato);
    @(negedge clk);
    valid_a[d] = 1'b1; addr_a[d] = a; wdata_a[d] = w; wstrb_a[d] = s; instr_a[d] = ins;
    lato = 0;
    do begin
      @(negedge clk);
      lato++;
    end while (ready_a[d] !== 1'b1 && lato < 40);
    rdo = rdata_a[d];
    valid_a[d] = 1'b0; wstrb_a[d] = 4'd0; instr_a[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b1; valid_a[d] = 1'b0; instr_a[d] = 1'b0;
      addr_a[d] = 32'd0; wdata_a[d] = 32'd0; wstrb_a[d] = 4'd0;
    end
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'd0, ready_a[0]}, 32'd0);
    check("rst_rdata",  rdata_a[0], 32'd0);
    check("rst_gpio",   gpio_a[0], 32'd0);
    check("rst_done",   {31'd0, done_a[0]}, 32'd0);
    check("rst_err",    {31'd0, err_a[0]}, 32'd0);
    check("rst_fc",     fc_a[0], 32'd0);
    for (int d = 0; d < 3; d++) rst_a[d] = 1'b0;

    // Zero wait states: write/read round trip
    xact(0, 32'h40, 32'hA5A5_1234, 4'hF, 1'b0, rd, lat);
    check("ws0_wr_lat", 32'(lat), 32'd1);
    xact(0, 32'h40, 32'h0, 4'h0, 1'b0, rd, lat);
    check("ws0_rd_lat", 32'(lat), 32'd1);
    check("ws0_rd_data", rd, 32'hA5A5_1234);
    check("ws0_no_err", {31'd0, err_a[0]}, 32'd0);
    repeat (4) @(negedge clk);
    check("rdata_hold", rdata_a[0], 32'hA5A5_1234);

    // Byte strobes; a write returns the pre-write word
    xact(0, 32'h80, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, lat);
    xact(0, 32'h80, 32'h0000_0000, 4'b0101, 1'b0, rd, lat);
    check("strb_prewrite", rd, 32'hFFFF_FFFF);
    xact(0, 32'h80, 32'h0, 4'h0, 1'b0, rd, lat);
    check("strb_rd", rd, 32'hFF00_FF00);

    // MMIO GPIO and DONE
    xact(0, MMIO, 32'h0000_00C3, 4'hF, 1'b0, rd, lat);
    check("gpio_c3", gpio_a[0], 32'h0000_00C3);
    xact(0, MMIO, 32'h1122_3344, 4'b1000, 1'b0, rd, lat);
    check("gpio_byte3", gpio_a[0], 32'h1100_00C3);
    xact(0, MMIO, 32'h0, 4'h0, 1'b0, rd, lat);
    check("gpio_rd", rd, 32'h1100_00C3);
    xact(0, MMIO + 32'h4, 32'h0, 4'h0, 1'b0, rd, lat);
    check("done_rd0", rd, 32'd0);
    check("done_pre", {31'd0, done_a[0]}, 32'd0);
    xact(0, MMIO + 32'h4, 32'h0, 4'b0001, 1'b0, rd, lat);
    check("done_set", {31'd0, done_a[0]}, 32'd1);
    repeat (3) @(negedge clk);
    check("done_sticky", {31'd0, done_a[0]}, 32'd1);
    xact(0, MMIO + 32'h4, 32'h0, 4'h0, 1'b0, rd, lat);
    check("done_rd1", rd, 32'd1);

    // CYCLES: deltas follow the bench's own edge count; writes are ignored
    xact(0, MMIO + 32'h8, 32'h0, 4'h0, 1'b0, c1, lat);
    t1 = tb_cyc;
    repeat (7) @(negedge clk);
    xact(0, MMIO + 32'h8, 32'h0, 4'h0, 1'b0, c2, lat);
    t2 = tb_cyc;
    check("cycles_delta", c2 - c1, t2 - t1);
    xact(0, MMIO + 32'h8, 32'h0, 4'hF, 1'b0, rd, lat);
    xact(0, MMIO + 32'h8, 32'h0, 4'h0, 1'b0, c3, lat);
    t3 = tb_cyc;
    check("cycles_wr_ignored", c3 - c2, t3 - t2);

    // Unmapped accesses still complete
    xact(0, 32'h2000_0000, 32'h0, 4'h0, 1'b0, rd, lat);
    check("err_lat", 32'(lat), 32'd1);
    check("err_rdata", rd, 32'hDEAD_BEEF);
    check("err_flag", {31'd0, err_a[0]}, 32'd1);
    xact(0, MMIO + 32'hC, 32'h0, 4'h0, 1'b0, rd, lat);
    check("err_mmio_hole", rd, 32'hDEAD_BEEF);
    xact(0, 32'h40, 32'h0, 4'h0, 1'b0, rd, lat);
    check("after_err_ram", rd, 32'hA5A5_1234);
    check("err_sticky", {31'd0, err_a[0]}, 32'd1);

    // Fetch counting, any region
    xact(0, 32'h40, 32'h0, 4'h0, 1'b1, rd, lat);
    xact(0, 32'h44, 32'h0, 4'h0, 1'b1, rd, lat);
    xact(0, 32'h3000_0000, 32'h0, 4'h0, 1'b1, rd, lat);
    check("fetch_count", fc_a[0], 32'd3);
    check("gpio_unchanged", gpio_a[0], 32'h1100_00C3);

    // Three wait states: latency, single-cycle strobe, throughput
    xact(1, 32'h0, 32'h1234_5678, 4'hF, 1'b0, rd, lat);
    check("ws3_wr_lat", 32'(lat), 32'd4);
    @(negedge clk);
    check("ws3_ready_1cyc", {31'd0, ready_a[1]}, 32'd0);
    @(negedge clk);
    valid_a[1] = 1'b1; addr_a[1] = 32'h0; wstrb_a[1] = 4'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (ready_a[1] !== 1'b1 && n < 40);
    check("ws3_rd_lat", 32'(n), 32'd4);
    check("ws3_rd_data", rdata_a[1], 32'h1234_5678);
    n = 0;
    do begin @(negedge clk); n++; end while (ready_a[1] !== 1'b1 && n < 40);
    check("ws3_period", 32'(n), 32'd5);
    valid_a[1] = 1'b0;

    // Reset in WAIT aborts a write (two wait states)
    xact(2, 32'h10, 32'hCAFE_0000, 4'hF, 1'b1, rd, lat);
    check("ws2_lat", 32'(lat), 32'd3);
    check("ws2_fc_pre", fc_a[2], 32'd1);
    @(negedge clk);
    valid_a[2] = 1'b1; addr_a[2] = 32'h10; wdata_a[2] = 32'h55; wstrb_a[2] = 4'hF;
    repeat (2) @(negedge clk);
    rst_a[2] = 1'b1;
    valid_a[2] = 1'b0; wstrb_a[2] = 4'h0;
    #1;
    check("rst_mid_ready", {31'd0, ready_a[2]}, 32'd0);
    check("rst_mid_rdata", rdata_a[2], 32'd0);
    check("rst_mid_fc", fc_a[2], 32'd0);
    @(negedge clk);
    rst_a[2] = 1'b0;
    saw_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready_a[2] !== 1'b0) saw_ready = 1'b1;
    end
    check("rst_no_ready", {31'd0, saw_ready}, 32'd0);
    xact(2, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat);
    check("rst_ram_sentinel", rd, 32'hCAFE_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
